// File: rtl/routing_pkg.sv
// Shared routing constants, address-width helpers and table FSM states.
package routing_pkg;

    localparam int unsigned ROUTER_PORTS        = 5;
    localparam int unsigned ROUTER_PORT_BITS    = 8;
    localparam int unsigned ROUTER_SIZE         = 8;
    localparam int unsigned ROUTER_DEFAULT_PORT = 4;

    // A flit of SIZE bits carries SIZE-1 destination bits.
    function automatic int unsigned dest_bits(input int unsigned size);
        return size - 1;
    endfunction

    function automatic int unsigned dests(input int unsigned size);
        return 1 << (size - 1);
    endfunction

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } rt_state_t;

endpackage

// File: rtl/routing_table_mem.sv
// Routing-table storage: one write port, a combinational lookup port and a
// registered read-back port. Contents are not reset.
module rt_mem #(
    parameter int unsigned ADDR_BITS = 7,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] lk_addr,
    output logic [DATA_BITS-1:0] lk_data,
    input  logic                 rd_clr,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Entry write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign lk_data = mem[lk_addr];

    // Read-back register; sees the pre-write value on a same-edge write.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/routing_table.sv
// Programmable routing table: init sweep, valid/ready config writes with range
// check, one-cycle read-back and combinational router lookup.
// Optional macro ROUTING_TABLE_BYPASS_EN forwards same-cycle legal writes to
// the lookup and read-back paths.
module routing_table
    import routing_pkg::*;
#(
    parameter int unsigned PORTS        = ROUTER_PORTS,
    parameter int unsigned PORT_BITS    = ROUTER_PORT_BITS,
    parameter int unsigned SIZE         = ROUTER_SIZE,
    parameter int unsigned DEFAULT_PORT = ROUTER_DEFAULT_PORT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [dest_bits(SIZE)-1:0]    table_addr,
    output logic [PORT_BITS-1:0]          table_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [dest_bits(SIZE)-1:0]    wr_addr,
    input  logic [PORT_BITS-1:0]          wr_data,
    output logic                          wr_err,
    input  logic                          rd_valid,
    input  logic [dest_bits(SIZE)-1:0]    rd_addr,
    output logic                          rd_resp_valid,
    output logic [PORT_BITS-1:0]          rd_resp_data,
    output logic                          init_done
);

    localparam int unsigned          DEST_BITS     = dest_bits(SIZE);
    localparam int unsigned          DESTS         = dests(SIZE);
    localparam logic [PORT_BITS-1:0] DEFAULT_ENTRY = PORT_BITS'(DEFAULT_PORT);
    localparam logic [DEST_BITS-1:0] LAST_IDX      = DEST_BITS'(DESTS - 1);

    rt_state_t            state, state_nxt;
    logic [DEST_BITS-1:0] init_idx;
    logic                 wr_fire, wr_legal;
    logic                 mem_we;
    logic [DEST_BITS-1:0] mem_waddr;
    logic [PORT_BITS-1:0] mem_wdata;
    logic [PORT_BITS-1:0] lk_data, mem_rd_data;
    logic                 fwd_lk, fwd_rd;
    logic                 rd_ovr;
    logic [PORT_BITS-1:0] rd_ovr_data;

    assign wr_ready  = (state == IDLE);
    assign init_done = (state == IDLE);
    assign wr_fire   = wr_valid & wr_ready;
    assign wr_legal  = (wr_data < PORT_BITS'(PORTS));

`ifdef ROUTING_TABLE_BYPASS_EN
    assign fwd_lk = wr_fire & wr_legal & (wr_addr == table_addr);
    assign fwd_rd = wr_fire & wr_legal & (wr_addr == rd_addr);
`else
    assign fwd_lk = 1'b0;
    assign fwd_rd = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep index: advances only while sweeping, wraps to 0 after the last entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            init_idx <= '0;
        end else if (state == INIT) begin
            init_idx <= init_idx + 1'b1;
        end
    end

    // Next state and table write-port selection.
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state)
            INIT: begin
                mem_we    = reset;
                mem_waddr = init_idx;
                mem_wdata = DEFAULT_ENTRY;
                if (init_idx == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                mem_we = wr_fire & wr_legal & reset;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Rejected-write pulse and read-back strobe/override capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_err        <= 1'b0;
            rd_resp_valid <= 1'b0;
            rd_ovr        <= 1'b0;
            rd_ovr_data   <= '0;
        end else begin
            wr_err        <= wr_fire & ~wr_legal;
            rd_resp_valid <= rd_valid;
            if (rd_valid) begin
                rd_ovr      <= (state == INIT) | fwd_rd;
                rd_ovr_data <= (state == INIT) ? DEFAULT_ENTRY : wr_data;
            end
        end
    end

    rt_mem #(
        .ADDR_BITS (DEST_BITS),
        .DATA_BITS (PORT_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (mem_waddr),
        .wr_data (mem_wdata),
        .lk_addr (table_addr),
        .lk_data (lk_data),
        .rd_clr  (~reset),
        .rd_en   (rd_valid),
        .rd_addr (rd_addr),
        .rd_data (mem_rd_data)
    );

    // The memory read register holds the stored value; the default-port and
    // forwarded cases are captured alongside it and override on the way out.
    assign rd_resp_data = rd_ovr ? rd_ovr_data : mem_rd_data;

    assign table_data = (state == INIT) ? DEFAULT_ENTRY :
                        fwd_lk          ? wr_data       : lk_data;

endmodule

// File: tb/tb_routing_table.sv
// Scoreboard bench for routing_table: random and directed config traffic
// against a table-level reference model.
`timescale 1ns/1ps
module tb_routing_table;

    localparam int unsigned DESTS = 128;
    localparam logic [7:0]  NP    = 8'd5;
    localparam logic [7:0]  DEFV  = 8'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] table_addr = '0;
    logic [7:0] table_data;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_err;
    logic       rd_valid = 1'b0;
    logic [6:0] rd_addr = '0;
    logic       rd_resp_valid;
    logic [7:0] rd_resp_data;
    logic       init_done;

    routing_table #(
        .PORTS        (5),
        .PORT_BITS    (8),
        .SIZE         (8),
        .DEFAULT_PORT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .table_addr    (table_addr),
        .table_data    (table_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_err        (wr_err),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_data  (rd_resp_data),
        .init_done     (init_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    bit          started = 1'b0;
    int unsigned init_cnt = 0;
    logic [7:0]  mdl [DESTS];
    logic [7:0]  rd_q [$];
    bit          err_q [$];

    function automatic bit in_init();
        return init_cnt < DESTS;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, using the inputs presented to it.
    task automatic model_edge();
        bit         busy;
        bit         fire;
        bit         legal;
        logic [7:0] r;
        if (!reset) begin
            init_cnt = 0;
            err_q.push_back(1'b0);
        end else begin
            busy  = in_init();
            fire  = wr_valid && !busy;
            legal = (wr_data < NP);
            if (rd_valid) begin
                r = busy ? DEFV : mdl[rd_addr];
`ifdef ROUTING_TABLE_BYPASS_EN
                if (fire && legal && wr_addr == rd_addr) r = wr_data;
`endif
                rd_q.push_back(r);
            end
            err_q.push_back(fire && !legal);
            if (fire && legal) mdl[wr_addr] = wr_data;
            if (busy) begin
                init_cnt++;
                if (init_cnt == DESTS) begin
                    for (int i = 0; i < DESTS; i++) mdl[i] = DEFV;
                end
            end
        end
    endtask

    // Combinational checks mid-cycle, then the model steps on the edge.
    task automatic cycle();
        logic [7:0] exp_td;
        @(negedge clk);
        if (started) begin
            exp_td = in_init() ? DEFV : mdl[table_addr];
`ifdef ROUTING_TABLE_BYPASS_EN
            if (!in_init() && wr_valid && wr_data < NP && wr_addr == table_addr) exp_td = wr_data;
`endif
            check_byte("table_data", table_data, exp_td);
            check_bit("wr_ready", wr_ready, !in_init());
            check_bit("init_done", init_done, !in_init());
        end
        @(posedge clk);
        model_edge();
        started = 1'b1;
        #1;
    endtask

    task automatic write(input int unsigned a, input int unsigned d);
        wr_valid   = 1'b1;
        wr_addr    = 7'(a);
        wr_data    = 8'(d);
        table_addr = 7'(a);
        cycle();
        wr_valid   = 1'b0;
    endtask

    // Monitor: registered outputs compared against queued expectations.
    always @(negedge clk) begin
        if (started) begin
            if (err_q.size() > 0) check_bit("wr_err", wr_err, err_q.pop_front());
            if (rd_q.size() > 0) begin
                check_bit("rd_resp_valid", rd_resp_valid, 1'b1);
                check_byte("rd_resp_data", rd_resp_data, rd_q.pop_front());
            end else begin
                check_bit("rd_resp_idle", rd_resp_valid, 1'b0);
            end
        end
    end

    initial begin
        // Reset, then the full sweep with a lookup of every address.
        repeat (3) cycle();
        reset = 1'b1;
        for (int i = 0; i < 132; i++) begin
            table_addr = 7'(i);
            rd_valid   = ($urandom % 4) == 0;
            rd_addr    = 7'($urandom);
            cycle();
        end
        rd_valid = 1'b0;

        // Directed writes and lookups.
        write(1, 2);
        write(2, 1);
        write(3, 2);
        write(0, 0);
        for (int i = 0; i < 6; i++) begin
            table_addr = 7'(i);
            cycle();
        end

        // Out-of-range write, then read back and look up the untouched entry.
        write(7, 5);
        rd_valid   = 1'b1;
        rd_addr    = 7'd7;
        table_addr = 7'd7;
        cycle();
        rd_valid = 1'b0;
        repeat (2) cycle();

        // Back-to-back reads of 2 with a write of 2 on the first edge.
        rd_valid   = 1'b1;
        rd_addr    = 7'd2;
        wr_valid   = 1'b1;
        wr_addr    = 7'd2;
        wr_data    = 8'd3;
        table_addr = 7'd2;
        cycle();
        wr_valid = 1'b0;
        cycle();
        rd_valid = 1'b0;
        cycle();

        // Random traffic concentrated on a few addresses to force collisions.
        for (int i = 0; i < 600; i++) begin
            wr_valid   = ($urandom % 2) == 0;
            wr_addr    = 7'($urandom % 8);
            wr_data    = 8'($urandom % 8);
            rd_valid   = ($urandom % 2) == 0;
            rd_addr    = ($urandom % 3 == 0) ? wr_addr : 7'($urandom % 8);
            table_addr = ($urandom % 3 == 0) ? wr_addr : 7'($urandom % 8);
            cycle();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;

        // Reset in IDLE, then again at sweep index 60; the sweep reruns fully.
        write(0, 2);
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        repeat (60) cycle();
        reset = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 7'd0;
        cycle();
        reset = 1'b1;
        table_addr = 7'd0;
        for (int i = 0; i < 132; i++) begin
            rd_valid = ($urandom % 4) == 0;
            rd_addr  = 7'd0;
            cycle();
        end
        rd_valid = 1'b0;

        // Write held pending through the whole sweep.
        reset = 1'b0;
        cycle();
        reset      = 1'b1;
        wr_valid   = 1'b1;
        wr_addr    = 7'd9;
        wr_data    = 8'd3;
        table_addr = 7'd9;
        repeat (DESTS + 1) cycle();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 7'd9;
        cycle();
        rd_valid = 1'b0;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
